wb_write_buffer: RTL

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

---
 rtl/wb_write_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_write_buffer.sv
// wb_write_buffer
//   Small FIFO of pending register-file writebacks. Accepted requests are
//   queued in order and drained one per cycle into a registered write port
//   whenever drain_en is high. Requests to register 0 are accepted and
//   dropped. An optional lookup (bypass) path reports the youngest pending
//   value for two read-port indices.
//
//   Optional feature macro: WB_WRITE_BUFFER_BYPASS_EN
//     defined   -> lk_hit*/lk_data* driven by the lookup logic
//     undefined -> lk_hit*/lk_data* tied to 0 (ports still present)
//
// Ports
//   clk            clock, all state updates on rising edge
//   rst_n          synchronous active-low reset
//   in_valid       writeback request present
//   in_ready       buffer can accept a request this cycle
//   in_reg/in_data destination register index / value
//   drain_en       register-file write port available this cycle
//   out_regwrite   register-file write enable
//   out_writereg   register-file write index
//   out_writedata  register-file write data
//   lk_reg1/2      lookup indices
//   lk_hit1/2      pending write exists for the lookup index
//   lk_data1/2     youngest pending value for the lookup index (0 on miss)
//   count          number of queued entries
module wb_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_reg,
   input  logic [15:0]              in_data,
   input  logic                     drain_en,
   output logic                     out_regwrite,
   output logic [2:0]               out_writereg,
   output logic [15:0]              out_writedata,
   input  logic [2:0]               lk_reg1,
   input  logic [2:0]               lk_reg2,
   output logic                     lk_hit1,
   output logic                     lk_hit2,
   output logic [15:0]              lk_data1,
   output logic [15:0]              lk_data2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [2:0]    mem_reg  [DEPTH];
   logic [15:0]   mem_data [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          accept;
   logic          push;
   logic          pop;

   assign in_ready = rst_n && (count < FULL);
   assign accept   = in_valid && in_ready;
   // Register 0 writes complete the handshake but never occupy a slot.
   assign push     = accept && (in_reg != 3'd0);
   assign pop      = drain_en && (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[tail]  <= in_reg;
         mem_data[tail] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         out_regwrite  <= 1'b0;
         out_writereg  <= '0;
         out_writedata <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            out_regwrite  <= 1'b1;
            out_writereg  <= mem_reg[head];
            out_writedata <= mem_data[head];
            head          <= head + 1'b1;
         end else begin
            out_regwrite  <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef WB_WRITE_BUFFER_BYPASS_EN
   logic [AW-1:0] idx;

   // Output register is the oldest candidate; queued entries are scanned
   // oldest to youngest so the last match wins.
   always_comb begin
      idx      = '0;
      lk_hit1  = 1'b0;
      lk_data1 = '0;
      lk_hit2  = 1'b0;
      lk_data2 = '0;
      if (out_regwrite && (lk_reg1 != 3'd0) && (out_writereg == lk_reg1)) begin
         lk_hit1  = 1'b1;
         lk_data1 = out_writedata;
      end
      if (out_regwrite && (lk_reg2 != 3'd0) && (out_writereg == lk_reg2)) begin
         lk_hit2  = 1'b1;
         lk_data2 = out_writedata;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + i[AW-1:0];
         if ((CW'(i) < count) && (lk_reg1 != 3'd0) && (mem_reg[idx] == lk_reg1)) begin
            lk_hit1  = 1'b1;
            lk_data1 = mem_data[idx];
         end
         if ((CW'(i) < count) && (lk_reg2 != 3'd0) && (mem_reg[idx] == lk_reg2)) begin
            lk_hit2  = 1'b1;
            lk_data2 = mem_data[idx];
         end
      end
   end
`else
   logic unused_lk;
   assign unused_lk = ^{lk_reg1, lk_reg2};
   assign lk_hit1   = 1'b0;
   assign lk_hit2   = 1'b0;
   assign lk_data1  = '0;
   assign lk_data2  = '0;
`endif

endmodule
